// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle instruction controller for a simple datapath with a memory port
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic        done,
  output logic        illegal,
  output logic        halted,
  input  logic [15:0] c_in,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        shiftsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        mem_req,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  input  logic        mem_ack
);

  typedef enum logic [3:0] {
    IDLE, WB_IMM, LD_A, LD_B, EXEC, WB, ADDR, STR_B, STR_EXEC, MEM, MEM_WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ILL, K_MOVI, K_MOVR, K_ALU, K_CMP, K_LDR, K_STR, K_HALT
  } kind_t;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       shiftsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
    logic       mem_req;
    logic       mem_we;
  } ctrl_t;

  state_t      state;
  kind_t       kind;
  kind_t       dk;
  ctrl_t       ctrl;
  logic [15:0] ir;
  logic        unused_c;

  function automatic kind_t decode(logic [4:0] w);
    kind_t k;
    k = K_ILL;
    case (w[4:2])
      3'b110: begin
        if (w[1:0] == 2'b10)      k = K_MOVI;
        else if (w[1:0] == 2'b00) k = K_MOVR;
      end
      3'b101: k = (w[1:0] == 2'b01) ? K_CMP : K_ALU;
      3'b011: if (w[1:0] == 2'b00) k = K_LDR;
      3'b100: if (w[1:0] == 2'b00) k = K_STR;
      3'b111: k = K_HALT;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // Outputs seen while sitting in state s; registered on the edge that enters s.
  function automatic ctrl_t outs(state_t s, kind_t k, logic [12:0] w);
    ctrl_t c;
    c = '0;
    case (s)
      WB_IMM: begin
        c.write    = 1'b1;
        c.vsel     = 2'b01;
        c.writenum = w[10:8];
      end
      LD_A: begin
        c.readnum = w[10:8];
        c.loada   = 1'b1;
      end
      LD_B: begin
        c.readnum = w[2:0];
        c.loadb   = 1'b1;
      end
      EXEC: begin
        if (k == K_LDR || k == K_STR) begin
          c.bsel  = 1'b1;
          c.loadc = 1'b1;
        end else begin
          c.asel   = (k == K_MOVR);
          c.shift  = w[4:3];
          c.alu_op = (k == K_MOVR) ? 2'b00 : w[12:11];
          c.loads  = (k == K_CMP);
          c.loadc  = (k != K_CMP);
        end
      end
      WB: begin
        c.write    = 1'b1;
        c.vsel     = 2'b00;
        c.writenum = w[7:5];
      end
      STR_B: begin
        c.readnum  = w[7:5];
        c.loadb    = 1'b1;
        c.shiftsel = 1'b1;
      end
      STR_EXEC: begin
        c.asel     = 1'b1;
        c.shiftsel = 1'b1;
        c.loadc    = 1'b1;
      end
      MEM: begin
        c.mem_req = 1'b1;
        c.mem_we  = (k == K_STR);
      end
      MEM_WB: begin
        c.write    = 1'b1;
        c.vsel     = 2'b11;
        c.writenum = w[7:5];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign dk = decode(instr[15:11]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      kind     <= K_ILL;
      ir       <= '0;
      ctrl     <= '0;
      mem_addr <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir   <= instr;
            kind <= dk;
            case (dk)
              K_MOVI: begin
                state <= WB_IMM;
                ctrl  <= outs(WB_IMM, dk, instr[12:0]);
              end
              K_MOVR: begin
                state <= LD_B;
                ctrl  <= outs(LD_B, dk, instr[12:0]);
              end
              K_ALU, K_CMP, K_LDR, K_STR: begin
                state <= LD_A;
                ctrl  <= outs(LD_A, dk, instr[12:0]);
              end
              K_HALT: begin
                state  <= HALT;
                halted <= 1'b1;
                ctrl   <= '0;
              end
              default: begin
                done    <= 1'b1;
                illegal <= 1'b1;
                ctrl    <= '0;
              end
            endcase
          end
        end
        WB_IMM, WB, MEM_WB: begin
          state <= IDLE;
          done  <= 1'b1;
          ctrl  <= '0;
        end
        LD_A: begin
          if (kind == K_LDR || kind == K_STR) begin
            state <= EXEC;
            ctrl  <= outs(EXEC, kind, ir[12:0]);
          end else begin
            state <= LD_B;
            ctrl  <= outs(LD_B, kind, ir[12:0]);
          end
        end
        LD_B: begin
          state <= EXEC;
          ctrl  <= outs(EXEC, kind, ir[12:0]);
        end
        EXEC: begin
          if (kind == K_CMP) begin
            state <= IDLE;
            done  <= 1'b1;
            ctrl  <= '0;
          end else if (kind == K_LDR || kind == K_STR) begin
            state <= ADDR;
            ctrl  <= '0;
          end else begin
            state <= WB;
            ctrl  <= outs(WB, kind, ir[12:0]);
          end
        end
        ADDR: begin
          // C now holds base + offset computed in EXEC
          mem_addr <= c_in[8:0];
          if (kind == K_STR) begin
            state <= STR_B;
            ctrl  <= outs(STR_B, kind, ir[12:0]);
          end else begin
            state <= MEM;
            ctrl  <= outs(MEM, kind, ir[12:0]);
          end
        end
        STR_B: begin
          state <= STR_EXEC;
          ctrl  <= outs(STR_EXEC, kind, ir[12:0]);
        end
        STR_EXEC: begin
          state <= MEM;
          ctrl  <= outs(MEM, kind, ir[12:0]);
        end
        MEM: begin
          if (mem_ack) begin
            if (kind == K_STR) begin
              state <= IDLE;
              done  <= 1'b1;
              ctrl  <= '0;
            end else begin
              state <= MEM_WB;
              ctrl  <= outs(MEM_WB, kind, ir[12:0]);
            end
          end
        end
        HALT: begin
          state <= HALT;
          ctrl  <= '0;
        end
        default: begin
          state <= IDLE;
          ctrl  <= '0;
        end
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign readnum     = ctrl.readnum;
  assign writenum    = ctrl.writenum;
  assign write       = ctrl.write;
  assign loada       = ctrl.loada;
  assign loadb       = ctrl.loadb;
  assign loadc       = ctrl.loadc;
  assign loads       = ctrl.loads;
  assign asel        = ctrl.asel;
  assign bsel        = ctrl.bsel;
  assign shiftsel    = ctrl.shiftsel;
  assign vsel        = ctrl.vsel;
  assign shift       = ctrl.shift;
  assign ALUop       = ctrl.alu_op;
  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign sximm5      = {{11{ir[4]}}, ir[4:0]};
  assign sximm8      = {{8{ir[7]}}, ir[7:0]};
  assign unused_c    = ^c_in[15:9];

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - scoreboard bench for datapath_ctrl
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready, done, illegal, halted;
  logic [15:0] c_in;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, shiftsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic        mem_ack;

  datapath_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .done(done), .illegal(illegal), .halted(halted),
    .c_in(c_in), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .bsel(bsel), .shiftsel(shiftsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  wire [65:0] zv = {done, illegal, halted, readnum, writenum, write, loada, loadb, loadc,
                    loads, asel, bsel, shiftsel, vsel, shift, ALUop, sximm5, sximm8,
                    mem_req, mem_we, mem_addr};
  wire [6:0] strb = {write, loada, loadb, loadc, loads, mem_req, mem_we};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   due;
    logic ill;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: each done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 at cycle %0d, required no done", cyc);
        end else begin
          got = sb.pop_front();
          if (cyc !== got.due || illegal !== got.ill) begin
            errors++;
            $display("FAIL done_timing: cycle %0d illegal %b, required cycle %0d illegal %b",
                     cyc, illegal, got.due, got.ill);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL done_missing: no done by cycle %0d, required at %0d", cyc, sb[0].due);
        got = sb.pop_front();
      end
    end
  end

  task automatic accept(input logic [15:0] w, input int lat, input logic ill, input bit push);
    exp_t e;
    for (int k = 0; k < 50 && !instr_ready; k++) @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    if (push) begin
      e.due = cyc + lat;
      e.ill = ill;
      sb.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    instr_valid = 1'b1;
    instr = 16'hD105;
    mem_ack = 1'b1;
    c_in = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ((^{instr_ready, zv}) === 1'bx) begin
      errors++;
      $display("FAIL reset_xfree: outputs %b contain X, required known", {instr_ready, zv});
    end
    @(negedge clk);
    checks++;
    if (zv !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", zv);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", instr_ready);
    end
    reset_n = 1'b1;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    c_in = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_mov_imm();
    accept(16'hD105, 2, 1'b0, 1'b1);
    checks++;
    if ({write, vsel, writenum} !== {1'b1, 2'b01, 3'd1}) begin
      errors++;
      $display("FAIL mov_imm_wb: got %b, required %b", {write, vsel, writenum}, 6'b101001);
    end
    checks++;
    if (sximm8 !== 16'h0005) begin
      errors++;
      $display("FAIL mov_imm_sximm8: got %h, required 0005", sximm8);
    end
    @(negedge clk);
    accept(16'hD2FD, 2, 1'b0, 1'b1);
    checks++;
    if ({sximm8, writenum} !== {16'hFFFD, 3'd2}) begin
      errors++;
      $display("FAIL mov_imm_neg: got %h/%0d, required FFFD/2", sximm8, writenum);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_alu();
    mem_ack = 1'b1;
    accept(16'hA0A1, 5, 1'b0, 1'b1);
    checks++;
    if ({loada, loadb, readnum} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL alu_lda: got %b, required 10000", {loada, loadb, readnum});
    end
    @(negedge clk);
    checks++;
    if ({loada, loadb, readnum} !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL alu_ldb: got %b, required 01001", {loada, loadb, readnum});
    end
    @(negedge clk);
    checks++;
    if ({loadc, loads, asel, bsel, ALUop} !== 6'b100000) begin
      errors++;
      $display("FAIL alu_exec: got %b, required 100000", {loadc, loads, asel, bsel, ALUop});
    end
    @(negedge clk);
    checks++;
    if ({write, vsel, writenum, mem_req} !== {1'b1, 2'b00, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb: got %b, required 1001010", {write, vsel, writenum, mem_req});
    end
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mov_reg();
    accept(16'hC0A9, 4, 1'b0, 1'b1);
    checks++;
    if ({loada, loadb, readnum} !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL movr_ldb: got %b, required 01001", {loada, loadb, readnum});
    end
    @(negedge clk);
    checks++;
    if ({asel, bsel, shift, ALUop, loadc} !== {1'b1, 1'b0, 2'b01, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL movr_exec: got %b, required 1001001", {asel, bsel, shift, ALUop, loadc});
    end
    @(negedge clk);
    checks++;
    if ({write, vsel, writenum} !== {1'b1, 2'b00, 3'd5}) begin
      errors++;
      $display("FAIL movr_wb: got %b, required 100101", {write, vsel, writenum});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_cmp();
    accept(16'hA923, 4, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({loads, loadc, ALUop} !== 4'b1001) begin
      errors++;
      $display("FAIL cmp_exec: got %b, required 1001", {loads, loadc, ALUop});
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("FAIL cmp_no_wb: write %b, required 0", write);
    end
    @(negedge clk);
  endtask

  task automatic test_ldr();
    int n;
    c_in = 16'h0103;
    accept(16'h6043, 9, 1'b0, 1'b1);
    checks++;
    if ({loada, readnum} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL ldr_lda: got %b, required 1000", {loada, readnum});
    end
    @(negedge clk);
    checks++;
    if ({loadc, asel, bsel, ALUop, sximm5} !== {1'b1, 1'b0, 1'b1, 2'b00, 16'h0003}) begin
      errors++;
      $display("FAIL ldr_exec: got %b/%h, required 10100/0003", {loadc, asel, bsel, ALUop}, sximm5);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ldr_addr_noreq: mem_req %b, required 0", mem_req);
    end
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 20 && mem_req; k++) begin
      n++;
      if (n == 1) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 9'h103}) begin
          errors++;
          $display("FAIL ldr_mem: got we %b addr %h, required 0/103", mem_we, mem_addr);
        end
      end
      mem_ack = (n == 4);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ldr_req_len: mem_req high %0d cycles, required 4", n);
    end
    checks++;
    if ({write, vsel, writenum, mem_req} !== {1'b1, 2'b11, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL ldr_memwb: got %b, required 1110100", {write, vsel, writenum, mem_req});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_str();
    c_in = 16'h01FF;
    accept(16'h8041, 7, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({shiftsel, loadb, readnum} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL str_b: got %b, required 11010", {shiftsel, loadb, readnum});
    end
    @(negedge clk);
    checks++;
    if ({asel, bsel, shiftsel, loadc, ALUop} !== 6'b101100) begin
      errors++;
      $display("FAIL str_exec: got %b, required 101100", {asel, bsel, shiftsel, loadc, ALUop});
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 9'h1FF}) begin
      errors++;
      $display("FAIL str_mem: got %b %b %h, required 1 1 1ff", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL str_release: mem_req %b, required 0", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_str_reset();
    accept(16'h8041, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin
      errors++;
      $display("FAIL strrst_mem: got %b, required 11", {mem_req, mem_we});
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, instr_ready, mem_addr} !== {1'b0, 1'b1, 9'h000}) begin
      errors++;
      $display("FAIL strrst_abort: got req %b ready %b addr %h, required 0 1 000",
               mem_req, instr_ready, mem_addr);
    end
    reset_n = 1'b1;
    c_in = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_halt();
    int bad;
    accept(16'hE000, 0, 1'b0, 1'b0);
    checks++;
    if ({halted, instr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL halt_enter: got %b, required 10", {halted, instr_ready});
    end
    instr = 16'hD105;
    instr_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || instr_ready || done || strb != 7'd0) bad++;
    end
    instr_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL halt_absorb: %0d bad cycles, required 0", bad);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({halted, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL halt_reset: got %b, required 01", {halted, instr_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    accept(16'h0000, 1, 1'b1, 1'b1);
    checks++;
    if ({strb, instr_ready} !== 8'b00000001) begin
      errors++;
      $display("FAIL illegal_quiet: got %b, required 00000001", {strb, instr_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[9] = '{16'h0000, 16'hD105, 16'hA0A1, 16'hC0A9, 16'hA923,
                              16'hB800, 16'h6800, 16'hC800, 16'hD2FD};
    int          lats[9]  = '{1, 2, 5, 4, 4, 5, 1, 1, 2};
    logic        ills[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          prev_due;
    exp_t        e;
    prev_due = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        checks++;
        if (cyc !== prev_due || instr_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_bubble: issue %0d at cycle %0d ready %b, required cycle %0d ready 1",
                   i, cyc, instr_ready, prev_due);
        end
      end
      instr = words[i];
      instr_valid = 1'b1;
      e.due = cyc + lats[i];
      e.ill = ills[i];
      sb.push_back(e);
      prev_due = e.due;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int k = 0; k < 20 && cyc < prev_due; k++) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    c_in = 16'h0000;
    mem_ack = 1'b0;
    test_reset();
    test_mov_imm();
    test_alu();
    test_mov_reg();
    test_cmp();
    test_ldr();
    test_str();
    test_str_reset();
    test_halt();
    test_illegal();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
